// File: rtl/mac_result_drain.sv
// Result drain for the 2x2 MAC array: gathers accumulator tiles into an N-entry
// requantized buffer, then streams the elements out over a valid/ready port.
module mac_result_drain #(
    parameter int ACC_W = 16,
    parameter int OUT_W = 8,
    parameter int N     = 16,
    parameter int SHIFT = 0,
    parameter int RELU  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 layer_start,
    input  logic                 capture_en,
    input  logic [2:0]           acc_sel,
    input  logic [ACC_W-1:0]     acc_out_0,
    input  logic [ACC_W-1:0]     acc_out_1,
    input  logic [ACC_W-1:0]     acc_out_2,
    input  logic [ACC_W-1:0]     acc_out_3,
    input  logic [3:0]           valid_out,
    output logic [OUT_W-1:0]     y_data,
    output logic [$clog2(N)-1:0] y_idx,
    output logic                 y_valid,
    input  logic                 y_ready,
    output logic                 y_last,
    output logic                 done,
    output logic                 busy,
    output logic                 dup_err,
    output logic                 range_err
);

    localparam int IDX_W = $clog2(N);
    localparam int TILES = N / 4;
    // Saturation bounds expressed at accumulator width (assumes ACC_W > OUT_W).
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (OUT_W - 1)));

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       mask_q, mask_d;
    logic [OUT_W-1:0]   res_q [N];
    logic [OUT_W-1:0]   res_d [N];
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               dup_q, dup_d;
    logic               rng_q, rng_d;
    logic               done_q, done_d;

    logic [ACC_W-1:0]   acc [4];
    logic [OUT_W-1:0]   rq  [4];
    logic               tile_ok;

    function automatic logic [OUT_W-1:0] requant(input logic [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = $signed(a) >>> SHIFT;
        if (RELU != 0 && s[ACC_W-1]) s = '0;
        if (s > SAT_MAX) s = SAT_MAX;
        if (s < SAT_MIN) s = SAT_MIN;
        return s[OUT_W-1:0];
    endfunction

    assign acc[0] = acc_out_0;
    assign acc[1] = acc_out_1;
    assign acc[2] = acc_out_2;
    assign acc[3] = acc_out_3;

    always_comb begin
        for (int k = 0; k < 4; k++) rq[k] = requant(acc[k]);
    end

    assign tile_ok = ({1'b0, acc_sel} < 4'(TILES));

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        res_d   = res_q;
        idx_d   = idx_q;
        dup_d   = dup_q;
        rng_d   = rng_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (layer_start) begin
                    state_d = COLLECT;
                    mask_d  = '0;
                    dup_d   = 1'b0;
                    rng_d   = 1'b0;
                    idx_d   = '0;
                end
            end
            COLLECT: begin
                // A restart wins over any capture presented in the same cycle.
                if (layer_start) begin
                    mask_d = '0;
                    dup_d  = 1'b0;
                    rng_d  = 1'b0;
                    idx_d  = '0;
                end else if (capture_en) begin
                    if (!tile_ok) begin
                        if (|valid_out) rng_d = 1'b1;
                    end else begin
                        for (int r = 0; r < N; r++) begin
                            if (valid_out[2'(r % 4)] && acc_sel == 3'(r / 4)) begin
                                if (mask_q[r]) dup_d = 1'b1;
                                res_d[r]  = rq[2'(r % 4)];
                                mask_d[r] = 1'b1;
                            end
                        end
                    end
                    if (&mask_d) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (y_ready) begin
                    if (idx_q == IDX_W'(N - 1)) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            idx_q   <= '0;
            dup_q   <= 1'b0;
            rng_q   <= 1'b0;
            done_q  <= 1'b0;
            for (int r = 0; r < N; r++) res_q[r] <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            dup_q   <= dup_d;
            rng_q   <= rng_d;
            done_q  <= done_d;
            res_q   <= res_d;
        end
    end

    // y_valid/y_data come straight from registers, so they hold during a stall.
    assign y_valid   = (state_q == DRAIN);
    assign y_data    = res_q[idx_q];
    assign y_idx     = idx_q;
    assign y_last    = y_valid && (idx_q == IDX_W'(N - 1));
    assign done      = done_q;
    assign busy      = (state_q != IDLE);
    assign dup_err   = dup_q;
    assign range_err = rng_q;

endmodule

// File: tb/tb_mac_result_drain.sv
// Bench for mac_result_drain: two instances (N=8 plain, N=4 with shift+ReLU)
// checked against a row-level model of collection, requantization and draining.
module tb_mac_result_drain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic ls [2];
  logic ce [2];
  logic yr [2];
  logic [2:0] sel [2];
  logic [3:0] vo [2];
  logic [15:0] acc [2][4];

  wire [7:0] yd [2];
  wire [2:0] yix [2];
  wire [2:0] yix0;
  wire [1:0] yix1;
  wire yv [2];
  wire yl [2];
  wire dn [2];
  wire bz [2];
  wire de [2];
  wire re [2];

  assign yix[0] = yix0;
  assign yix[1] = {1'b0, yix1};

  mac_result_drain #(.ACC_W(16), .OUT_W(8), .N(8), .SHIFT(0), .RELU(0)) dut0 (
    .clk(clk), .rst(rst), .layer_start(ls[0]), .capture_en(ce[0]), .acc_sel(sel[0]),
    .acc_out_0(acc[0][0]), .acc_out_1(acc[0][1]), .acc_out_2(acc[0][2]), .acc_out_3(acc[0][3]),
    .valid_out(vo[0]), .y_data(yd[0]), .y_idx(yix0), .y_valid(yv[0]), .y_ready(yr[0]),
    .y_last(yl[0]), .done(dn[0]), .busy(bz[0]), .dup_err(de[0]), .range_err(re[0])
  );

  mac_result_drain #(.ACC_W(16), .OUT_W(8), .N(4), .SHIFT(2), .RELU(1)) dut1 (
    .clk(clk), .rst(rst), .layer_start(ls[1]), .capture_en(ce[1]), .acc_sel(sel[1]),
    .acc_out_0(acc[1][0]), .acc_out_1(acc[1][1]), .acc_out_2(acc[1][2]), .acc_out_3(acc[1][3]),
    .valid_out(vo[1]), .y_data(yd[1]), .y_idx(yix1), .y_valid(yv[1]), .y_ready(yr[1]),
    .y_last(yl[1]), .done(dn[1]), .busy(bz[1]), .dup_err(de[1]), .range_err(re[1])
  );

  // Reference model: per instance, the row values, which rows were written,
  // sticky error flags and a coarse phase (0 idle, 1 collecting, 2 draining).
  int nr [2] = '{8, 4};
  int shv [2] = '{0, 2};
  int rlv [2] = '{0, 1};
  int m_val [2][8];
  bit m_mask [2][8];
  bit m_dup [2];
  bit m_rng [2];
  int m_st [2];

  int n_tests = 0;
  int n_fail = 0;

  function automatic int rq_model(int d, logic [15:0] a);
    int v;
    v = int'($signed(a));
    v = v >>> shv[d];
    if (rlv[d] != 0 && v < 0) v = 0;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int d = 0; d < 2; d++) begin
      ls[d] = 1'b0; ce[d] = 1'b0; sel[d] = '0; vo[d] = '0; yr[d] = 1'b0;
      for (int k = 0; k < 4; k++) acc[d][k] = '0;
    end
  endtask

  task automatic model_clear(int d);
    for (int r = 0; r < 8; r++) m_mask[d][r] = 1'b0;
    m_dup[d] = 1'b0;
    m_rng[d] = 1'b0;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      model_clear(d);
      m_st[d] = 0;
      for (int r = 0; r < 8; r++) m_val[d][r] = 0;
    end
  endtask

  // One collection-phase cycle: drive, advance the model, clock, then compare.
  task automatic cap(int d, bit l, bit c, logic [2:0] s, logic [3:0] v,
                     logic [15:0] a0, logic [15:0] a1, logic [15:0] a2, logic [15:0] a3);
    int r;
    bit all;
    ls[d] = l; ce[d] = c; sel[d] = s; vo[d] = v;
    acc[d][0] = a0; acc[d][1] = a1; acc[d][2] = a2; acc[d][3] = a3;
    if (m_st[d] == 0) begin
      if (l) begin
        model_clear(d);
        m_st[d] = 1;
      end
    end else if (m_st[d] == 1) begin
      if (l) begin
        model_clear(d);
      end else if (c) begin
        if (int'(s) >= nr[d] / 4) begin
          if (v != 4'b0000) m_rng[d] = 1'b1;
        end else begin
          for (int k = 0; k < 4; k++) begin
            if (v[k]) begin
              r = 4 * int'(s) + k;
              if (m_mask[d][r]) m_dup[d] = 1'b1;
              m_val[d][r] = rq_model(d, acc[d][k]);
              m_mask[d][r] = 1'b1;
            end
          end
          all = 1'b1;
          for (int q = 0; q < nr[d]; q++) if (!m_mask[d][q]) all = 1'b0;
          if (all) m_st[d] = 2;
        end
      end
    end
    step();
    ls[d] = 1'b0; ce[d] = 1'b0; vo[d] = '0;
    n_tests++;
    if (yv[d] !== (m_st[d] == 2)) begin
      n_fail++; $display("FAIL cap_y_valid dut%0d: got %b want %b", d, yv[d], (m_st[d] == 2));
    end
    n_tests++;
    if (bz[d] !== (m_st[d] != 0)) begin
      n_fail++; $display("FAIL cap_busy dut%0d: got %b want %b", d, bz[d], (m_st[d] != 0));
    end
    n_tests++;
    if (de[d] !== m_dup[d]) begin
      n_fail++; $display("FAIL cap_dup_err dut%0d: got %b want %b", d, de[d], m_dup[d]);
    end
    n_tests++;
    if (re[d] !== m_rng[d]) begin
      n_fail++; $display("FAIL cap_range_err dut%0d: got %b want %b", d, re[d], m_rng[d]);
    end
    n_tests++;
    if (dn[d] !== 1'b0) begin
      n_fail++; $display("FAIL cap_done dut%0d: got %b want 0", d, dn[d]);
    end
  endtask

  task automatic start(int d);
    cap(d, 1'b1, 1'b0, 3'd0, 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0);
  endtask

  task automatic fill_random(int d);
    for (int t = 0; t < nr[d] / 4; t++)
      cap(d, 1'b0, 1'b1, 3'(t), 4'b1111, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
  endtask

  // mode 0: always ready; 1: ready pattern 1,0,0,1; 2: random ready plus
  // random (ignored) layer_start/captures. stop_at >= 0 abandons the drain
  // when that index is presented.
  task automatic drain(int d, int mode, int stop_at);
    int idx = 0;
    int cyc = 0;
    int pat [4] = '{1, 0, 0, 1};
    while (idx < nr[d] && cyc < 200) begin
      if (stop_at >= 0 && idx == stop_at) begin
        yr[d] = 1'b0;
        return;
      end
      if (mode == 0) yr[d] = 1'b1;
      else if (mode == 1) yr[d] = pat[cyc % 4][0];
      else begin
        yr[d] = 1'($urandom_range(0, 1));
        ls[d] = 1'($urandom_range(0, 1));
        ce[d] = 1'($urandom_range(0, 1));
        vo[d] = 4'($urandom);
        sel[d] = 3'($urandom_range(0, 7));
        for (int k = 0; k < 4; k++) acc[d][k] = 16'($urandom);
      end
      n_tests++;
      if (yv[d] !== 1'b1) begin
        n_fail++; $display("FAIL drain_y_valid dut%0d idx %0d: got %b want 1", d, idx, yv[d]);
      end
      n_tests++;
      if (yix[d] !== 3'(idx)) begin
        n_fail++; $display("FAIL drain_y_idx dut%0d: got %0d want %0d", d, yix[d], idx);
      end
      n_tests++;
      if (yd[d] !== 8'(m_val[d][idx])) begin
        n_fail++; $display("FAIL drain_y_data dut%0d idx %0d: got %0d want %0d", d, idx,
                           $signed(yd[d]), m_val[d][idx]);
      end
      n_tests++;
      if (yl[d] !== (idx == nr[d] - 1)) begin
        n_fail++; $display("FAIL drain_y_last dut%0d idx %0d: got %b want %b", d, idx, yl[d],
                           (idx == nr[d] - 1));
      end
      n_tests++;
      if (dn[d] !== 1'b0) begin
        n_fail++; $display("FAIL drain_done_early dut%0d idx %0d: got %b want 0", d, idx, dn[d]);
      end
      step();
      cyc++;
      if (yr[d]) idx++;
    end
    yr[d] = 1'b0; ls[d] = 1'b0; ce[d] = 1'b0; vo[d] = '0;
    n_tests++;
    if (idx < nr[d]) begin
      n_fail++; $display("FAIL drain_timeout dut%0d: reached %0d want %0d", d, idx, nr[d]);
    end
    m_st[d] = 0;
    n_tests++;
    if (dn[d] !== 1'b1) begin
      n_fail++; $display("FAIL drain_done_pulse dut%0d: got %b want 1", d, dn[d]);
    end
    n_tests++;
    if (bz[d] !== 1'b0 || yv[d] !== 1'b0 || yix[d] !== 3'd0) begin
      n_fail++; $display("FAIL drain_end_idle dut%0d: busy %b valid %b idx %0d want 0 0 0", d,
                         bz[d], yv[d], yix[d]);
    end
    step();
    n_tests++;
    if (dn[d] !== 1'b0) begin
      n_fail++; $display("FAIL drain_done_width dut%0d: got %b want 0", d, dn[d]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    model_reset();
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (yv[d] !== 1'b0 || yd[d] !== 8'd0 || yix[d] !== 3'd0 || yl[d] !== 1'b0 ||
          dn[d] !== 1'b0 || bz[d] !== 1'b0 || de[d] !== 1'b0 || re[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d: v%b d%0d i%0d l%b dn%b bz%b de%b re%b want all 0",
                 d, yv[d], yd[d], yix[d], yl[d], dn[d], bz[d], de[d], re[d]);
      end
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic();
    start(0);
    cap(0, 1'b0, 1'b1, 3'd0, 4'b1111, 16'd10, 16'd20, 16'd30, 16'd40);
    cap(0, 1'b0, 1'b1, 3'd1, 4'b1111, 16'd50, 16'd60, 16'd70, 16'd80);
    drain(0, 0, -1);
  endtask

  task automatic test_requant();
    start(1);
    cap(1, 1'b0, 1'b1, 3'd0, 4'b1111, 16'(-100), 16'd300, 16'd1000, 16'd7);
    drain(1, 0, -1);
    start(0);
    cap(0, 1'b0, 1'b1, 3'd0, 4'b1111, 16'(-100), 16'd300, 16'd1000, 16'd7);
    cap(0, 1'b0, 1'b1, 3'd1, 4'b1111, 16'(-1000), 16'h7fff, 16'h8000, 16'd127);
    drain(0, 0, -1);
  endtask

  task automatic test_partial_backpressure();
    start(0);
    for (int t = 0; t < 2; t++) begin
      cap(0, 1'b0, 1'b1, 3'(t), 4'b0011, 16'($urandom_range(0, 250)), 16'($urandom_range(0, 250)),
          16'd0, 16'd0);
      cap(0, 1'b0, 1'b1, 3'(t), 4'b1100, 16'd0, 16'd0, 16'($urandom_range(0, 250)),
          16'($urandom_range(0, 250)));
    end
    drain(0, 1, -1);
  endtask

  task automatic test_errors();
    start(0);
    cap(0, 1'b0, 1'b1, 3'd0, 4'b0100, 16'd0, 16'd0, 16'd5, 16'd0);
    cap(0, 1'b0, 1'b1, 3'd0, 4'b0100, 16'd0, 16'd0, 16'd9, 16'd0);
    cap(0, 1'b0, 1'b1, 3'd3, 4'b1111, 16'd111, 16'd112, 16'd113, 16'd114);
    cap(0, 1'b0, 1'b0, 3'd1, 4'b1111, 16'd99, 16'd99, 16'd99, 16'd99);
    cap(0, 1'b0, 1'b1, 3'd0, 4'b1011, 16'd1, 16'd2, 16'd0, 16'd4);
    cap(0, 1'b0, 1'b1, 3'd1, 4'b1111, 16'd11, 16'd12, 16'd13, 16'd14);
    drain(0, 0, -1);
  endtask

  task automatic test_restart();
    start(0);
    cap(0, 1'b0, 1'b1, 3'd0, 4'b1111, 16'd1, 16'd2, 16'd3, 16'd4);
    cap(0, 1'b1, 1'b1, 3'd1, 4'b1111, 16'd5, 16'd6, 16'd7, 16'd8);
    cap(0, 1'b0, 1'b1, 3'd1, 4'b1111, 16'd21, 16'd22, 16'd23, 16'd24);
    cap(0, 1'b0, 1'b1, 3'd0, 4'b1111, 16'd31, 16'd32, 16'd33, 16'd34);
    drain(0, 0, -1);
  endtask

  task automatic test_random(int d, int iters);
    int cyc;
    logic [15:0] a [4];
    for (int it = 0; it < iters; it++) begin
      start(d);
      cyc = 0;
      while (m_st[d] != 2 && cyc < 300) begin
        for (int k = 0; k < 4; k++)
          a[k] = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 600) - 300);
        cap(d, ($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, nr[d] / 4)),
            4'($urandom), a[0], a[1], a[2], a[3]);
        cyc++;
      end
      n_tests++;
      if (m_st[d] != 2) begin
        n_fail++; $display("FAIL random_collect_timeout dut%0d: got phase %0d want 2", d, m_st[d]);
      end else begin
        drain(d, 2, -1);
      end
    end
  endtask

  task automatic test_reset_drain();
    start(0);
    fill_random(0);
    drain(0, 0, 3);
    n_tests++;
    if (yix[0] !== 3'd3 || yv[0] !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre_idx: got idx %0d valid %b want 3 1", yix[0], yv[0]);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (yv[0] !== 1'b0 || bz[0] !== 1'b0 || yix[0] !== 3'd0) begin
      n_fail++; $display("FAIL rst_async: valid %b busy %b idx %0d want 0 0 0", yv[0], bz[0], yix[0]);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_tests++;
      if (dn[0] !== 1'b0 || bz[0] !== 1'b0) begin
        n_fail++; $display("FAIL rst_no_done cycle %0d: done %b busy %b want 0 0", c, dn[0], bz[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_requant();
    test_partial_backpressure();
    test_errors();
    test_restart();
    test_random(0, 6);
    test_random(1, 6);
    test_reset_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
